// File: rtl/mul_share_arbiter_pkg.sv
// Shared types for the two-way multiplier sharing arbiter: FSM encoding,
// default sizing and a small index-to-one-hot helper.
package mul_share_arbiter_pkg;
    localparam int W_DEF   = 64;
    localparam int TMO_DEF = 255;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CLR  = 3'd1,
        RUN  = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } state_t;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction
endpackage

// File: rtl/mul_share_arbiter_if.sv
// Requester-side bus and multiplier-side bus of the sharing arbiter.
// In both, master is the side that issues the job and slave the side that serves it.
interface mul_share_arbiter_if #(parameter int W = 64);
    logic [1:0]     req;
    logic [2*W-1:0] req_mcand;
    logic [2*W-1:0] req_mplier;
    logic [1:0]     gnt;
    logic [1:0]     done;
    logic [1:0]     err;
    logic [2*W-1:0] result;
    logic           busy;

    modport master (output req, req_mcand, req_mplier,
                    input  gnt, done, err, result, busy);
    modport slave  (input  req, req_mcand, req_mplier,
                    output gnt, done, err, result, busy);
endinterface

interface mul_share_arbiter_mul_if #(parameter int W = 64);
    logic           mul_opclear;
    logic           mul_opstart;
    logic [W-1:0]   mul_mcand;
    logic [W-1:0]   mul_mplier;
    logic           mul_opdone;
    logic [2*W-1:0] mul_result;

    modport master (output mul_opclear, mul_opstart, mul_mcand, mul_mplier,
                    input  mul_opdone, mul_result);
    modport slave  (input  mul_opclear, mul_opstart, mul_mcand, mul_mplier,
                    output mul_opdone, mul_result);
endinterface

// File: rtl/mul_share_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick; rr_ptr only matters when both request.
module rr_arb2
    import mul_share_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       rr_ptr,
    output logic [1:0] pick
);
    always_comb begin
        pick = 2'b00;
        case (req)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11:   pick = onehot2(rr_ptr);
            default: pick = 2'b00;
        endcase
    end
endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one multiplier between two requesters: round-robin grant, operand
// latch, clear/start/done sequencing, and a RUN-cycle timeout abort.
module mul_share_arbiter
    import mul_share_arbiter_pkg::*;
#(
    parameter int W       = W_DEF,
    parameter int TMO_CYC = TMO_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    mul_share_arbiter_if.slave      rq,
    mul_share_arbiter_mul_if.master mul
);
    localparam int CW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(TMO_CYC - 1);

    state_t        state, nxt;
    logic          owner, own_nxt, rr_ptr;
    logic [1:0]    pick;
    logic [CW-1:0] tmo_cnt;

    rr_arb2 u_arb (.req(rq.req), .rr_ptr(rr_ptr), .pick(pick));

    always_comb begin
        nxt     = state;
        own_nxt = owner;
        case (state)
            IDLE: if (|pick) begin
                nxt     = CLR;
                own_nxt = pick[1];
            end
            CLR:  nxt = RUN;
            // A completion seen on the timeout cycle still counts as success.
            RUN:  if (mul.mul_opdone)          nxt = DONE;
                  else if (tmo_cnt == TMO_LAST) nxt = ERR;
            DONE: nxt = IDLE;
            ERR:  nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so each one lines up with its state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            owner           <= 1'b0;
            rr_ptr          <= 1'b0;
            tmo_cnt         <= '0;
            rq.gnt          <= 2'b00;
            rq.done         <= 2'b00;
            rq.err          <= 2'b00;
            rq.result       <= '0;
            rq.busy         <= 1'b0;
            mul.mul_opclear <= 1'b0;
            mul.mul_opstart <= 1'b0;
            mul.mul_mcand   <= '0;
            mul.mul_mplier  <= '0;
        end else begin
            state           <= nxt;
            owner           <= own_nxt;
            rq.busy         <= (nxt != IDLE);
            rq.gnt          <= (nxt != IDLE) ? onehot2(own_nxt) : 2'b00;
            rq.done         <= (nxt == DONE) ? onehot2(own_nxt) : 2'b00;
            rq.err          <= (nxt == ERR)  ? onehot2(own_nxt) : 2'b00;
            mul.mul_opclear <= (nxt == CLR) || (nxt == ERR);
            mul.mul_opstart <= (nxt == RUN);

            if (state == IDLE && nxt == CLR) begin
                mul.mul_mcand  <= pick[1] ? rq.req_mcand[W +: W]  : rq.req_mcand[0 +: W];
                mul.mul_mplier <= pick[1] ? rq.req_mplier[W +: W] : rq.req_mplier[0 +: W];
            end

            if (nxt == CLR)
                tmo_cnt <= '0;
            else if (state == RUN)
                tmo_cnt <= tmo_cnt + 1'b1;

            if (state == RUN && mul.mul_opdone)
                rq.result <= mul.mul_result;

            if (state == DONE || state == ERR)
                rr_ptr <= ~owner;
        end
    end
endmodule
